// File: rtl/object_package.sv
// Shared types for the Pong score keeper: ball zones, match states and winner codes.
package object_package;

  typedef enum logic [1:0] {
    ZONE_IN,
    ZONE_LEFT,
    ZONE_RIGHT
  } zone_t;

  typedef enum logic [1:0] {
    ST_PLAY,
    ST_HOLD,
    ST_OVER
  } match_state_t;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;

endpackage

// File: rtl/score_keeper_multi_if.sv
// Ball-physics-to-scoreboard bus: ball positions in, scores and match status out.
interface score_keeper_multi_if #(
  parameter int unsigned NBALLS = 2,
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned SBITS  = 4
);
  logic [NBALLS-1:0][WIDTH-1:0] ball_x;
  logic [NBALLS-1:0]            ball_valid;
  logic                         restart;
  logic [SBITS-1:0]             s1;
  logic [SBITS-1:0]             s2;
  logic                         point_p1;
  logic                         point_p2;
  logic                         serve_hold;
  logic                         gameover;
  logic [1:0]                   winner;

  modport master (
    output ball_x, ball_valid, restart,
    input  s1, s2, point_p1, point_p2, serve_hold, gameover, winner
  );

  modport slave (
    input  ball_x, ball_valid, restart,
    output s1, s2, point_p1, point_p2, serve_hold, gameover, winner
  );
endinterface

// File: rtl/ball_exit_detector.sv
// Classifies one ball's x into a zone and flags the cycle it leaves the field.
module ball_exit_detector
  import object_package::*;
#(
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned SCREEN_WIDTH = 640 << 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic             valid,
  output logic             exit_left_c,
  output logic             exit_right_c
);
  // Positions above twice the field width are negative values that wrapped.
  localparam logic [WIDTH:0] EDGE_R = (WIDTH+1)'(SCREEN_WIDTH);
  localparam logic [WIDTH:0] EDGE_L = (WIDTH+1)'(2 * SCREEN_WIDTH);

  zone_t zone_c;
  zone_t prev_q;

  always_comb begin
    zone_c = ZONE_IN;
    if ({1'b0, x} > EDGE_L)      zone_c = ZONE_LEFT;
    else if ({1'b0, x} > EDGE_R) zone_c = ZONE_RIGHT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= ZONE_IN;
    else        prev_q <= zone_c;
  end

  assign exit_left_c  = valid && (prev_q == ZONE_IN) && (zone_c == ZONE_LEFT);
  assign exit_right_c = valid && (prev_q == ZONE_IN) && (zone_c == ZONE_RIGHT);

endmodule

// File: rtl/score_keeper_multi.sv
// Multi-ball Pong scoreboard: counts exit edges, saturates scores, runs PLAY/HOLD/OVER.
module score_keeper_multi
  import object_package::*;
#(
  parameter int unsigned NBALLS       = 2,
  parameter int unsigned SBITS        = 4,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned WIN_BY       = 1,
  parameter int unsigned FBITS        = 4,
  parameter int unsigned WIDTH        = 16,
  parameter int unsigned SCREEN_WIDTH = 640 << FBITS,
  parameter int unsigned HOLD_CYCLES  = 50_000_000
) (
  input logic                 clk,
  input logic                 rst_n,
  score_keeper_multi_if.slave bus
);
  localparam int unsigned CBITS = $clog2(NBALLS + 1);
  localparam int unsigned SW    = SBITS + 2;
  localparam int unsigned TBITS = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SBITS:0] SMAX = {1'b0, {SBITS{1'b1}}};
  localparam logic signed [SW-1:0] WIN_S = SW'(WIN_SCORE);
  localparam logic signed [SW-1:0] BY_S  = SW'(WIN_BY);

  logic [NBALLS-1:0] exit_left_c, exit_right_c;

  for (genvar i = 0; i < NBALLS; i++) begin : g_ball
    ball_exit_detector #(
      .WIDTH       (WIDTH),
      .SCREEN_WIDTH(SCREEN_WIDTH)
    ) u_det (
      .clk         (clk),
      .rst_n       (rst_n),
      .x           (bus.ball_x[i]),
      .valid       (bus.ball_valid[i]),
      .exit_left_c (exit_left_c[i]),
      .exit_right_c(exit_right_c[i])
    );
  end

  function automatic logic [SBITS-1:0] sat_add(input logic [SBITS-1:0] s,
                                                input logic [CBITS-1:0] c);
    logic [SBITS:0] sum;
    sum = (SBITS+1)'(s) + (SBITS+1)'(c);
    return (sum > SMAX) ? SBITS'(SMAX) : SBITS'(sum);
  endfunction

  match_state_t     state_q, state_d;
  logic [SBITS-1:0] s1_q, s1_d, s2_q, s2_d, s1_n, s2_n;
  logic             pt1_q, pt1_d, pt2_q, pt2_d, hold_q, over_q;
  logic [1:0]       winner_q, winner_d, win_c;
  logic [TBITS-1:0] timer_q, timer_d;
  logic [CBITS-1:0] cnt_l, cnt_r;
  logic signed [SW-1:0] s1_w, s2_w;
  logic             q1, q2;

  // Left exits score for player 2, right exits for player 1.
  always_comb begin
    cnt_l = '0;
    cnt_r = '0;
    for (int unsigned i = 0; i < NBALLS; i++) begin
      cnt_l = cnt_l + CBITS'(exit_left_c[i]);
      cnt_r = cnt_r + CBITS'(exit_right_c[i]);
    end
  end

  assign s1_n = sat_add(s1_q, cnt_r);
  assign s2_n = sat_add(s2_q, cnt_l);
  assign s1_w = $signed({2'b00, s1_n});
  assign s2_w = $signed({2'b00, s2_n});
  assign q1   = (s1_w >= WIN_S) && (s1_w >= s2_w + BY_S);
  assign q2   = (s2_w >= WIN_S) && (s2_w >= s1_w + BY_S);

  // When both qualify only a strictly higher score wins.
  always_comb begin
    win_c = WIN_NONE;
    if (q1 && q2) begin
      if (s1_n > s2_n)      win_c = WIN_P1;
      else if (s2_n > s1_n) win_c = WIN_P2;
    end else if (q1) begin
      win_c = WIN_P1;
    end else if (q2) begin
      win_c = WIN_P2;
    end
  end

  always_comb begin
    state_d  = state_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    pt1_d    = 1'b0;
    pt2_d    = 1'b0;
    winner_d = winner_q;
    timer_d  = timer_q;
    if (bus.restart) begin
      state_d  = ST_PLAY;
      s1_d     = '0;
      s2_d     = '0;
      winner_d = WIN_NONE;
      timer_d  = '0;
    end else begin
      unique case (state_q)
        ST_PLAY: begin
          if ((cnt_l != '0) || (cnt_r != '0)) begin
            s1_d  = s1_n;
            s2_d  = s2_n;
            pt1_d = (cnt_r != '0);
            pt2_d = (cnt_l != '0);
            if (win_c != WIN_NONE) begin
              state_d  = ST_OVER;
              winner_d = win_c;
            end else begin
              state_d = ST_HOLD;
              timer_d = TBITS'(HOLD_CYCLES - 1);
            end
          end
        end
        ST_HOLD: begin
          if (timer_q == '0) state_d = ST_PLAY;
          else               timer_d = timer_q - TBITS'(1);
        end
        ST_OVER: begin
        end
        default: state_d = ST_PLAY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_PLAY;
      s1_q     <= '0;
      s2_q     <= '0;
      pt1_q    <= 1'b0;
      pt2_q    <= 1'b0;
      hold_q   <= 1'b0;
      over_q   <= 1'b0;
      winner_q <= WIN_NONE;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      pt1_q    <= pt1_d;
      pt2_q    <= pt2_d;
      hold_q   <= (state_d == ST_HOLD);
      over_q   <= (state_d == ST_OVER);
      winner_q <= winner_d;
      timer_q  <= timer_d;
    end
  end

  assign bus.s1         = s1_q;
  assign bus.s2         = s2_q;
  assign bus.point_p1   = pt1_q;
  assign bus.point_p2   = pt2_q;
  assign bus.serve_hold = hold_q;
  assign bus.gameover   = over_q;
  assign bus.winner     = winner_q;

endmodule

// File: doc/score_keeper_multi.md
Name: score_keeper_multi

Overview:
Parametrised scoreboard and match controller for Pong with N balls, a configurable winning score and a configurable win margin. It classifies each ball's x position as in-field, left-out or right-out, and scores one point per exit edge rather than once per cycle. A PLAY/HOLD/OVER state machine inserts a serve pause after each point and latches the winner. It sits between the ball physics blocks and the score/word display logic.

Parameters:
NBALLS, 2, number of balls tracked.
SBITS, 4, score counter width; counters saturate at 2^SBITS-1.
WIN_SCORE, 7, minimum score needed to win.
WIN_BY, 1, required lead over the opponent to win (1 = plain first-to, 2 = win-by-two).
SCREEN_WIDTH, 640<<FBITS, play-field width in fixed-point units (WIDTH bits).
HOLD_CYCLES, 50_000_000, serve-pause length in clk cycles; must be ≥1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ball_x  in  NBALLS x WIDTH  fixed-point x position of each ball (object.x)
ball_valid  in  NBALLS  ball i is active; an inactive ball never scores
restart  in  1  synchronous pulse: clear the match and return to PLAY
s1  out  SBITS  player-1 (left) score
s2  out  SBITS  player-2 (right) score
point_p1  out  1  one-cycle pulse when player 1 scores at least one point
point_p2  out  1  one-cycle pulse when player 2 scores at least one point
serve_hold  out  1  high while in HOLD
gameover  out  1  high while in OVER
winner  out  2  0 = none, 1 = player 1, 2 = player 2

Behaviour:
- Zone per ball (combinational):
  - LEFT_OUT if x > 2*SCREEN_WIDTH (negative wrap).
  - RIGHT_OUT if SCREEN_WIDTH < x ≤ 2*SCREEN_WIDTH.
  - IN otherwise.
- The previous zone per ball is registered every cycle in all states. An exit event fires when the previous zone is IN, the current zone is not IN, and ball_valid[i]=1. A ball that stays out scores once only.
- L = count of LEFT_OUT events (these score for p2). R = count of RIGHT_OUT events (these score for p1). Each count is 0..NBALLS, summed in the same cycle.
- The next score is the current score plus the count, computed at SBITS+1 bits and clamped to 2^SBITS-1.
- PLAY:
  - If any event occurs, update s1/s2 and pulse point_p1 if R>0 and point_p2 if L>0.
  - Win test uses the updated scores, at SBITS+2 signed width:
    - p1 wins if s1' ≥ WIN_SCORE and s1' ≥ s2'+WIN_BY;
    - p2 wins symmetrically.
    - If both qualify, the strictly higher score wins. Equal scores with WIN_BY≥1 cannot both qualify, so there is no winner.
  - Win → OVER next cycle, with winner set and gameover=1.
  - Event but no win → HOLD, with the timer loaded with HOLD_CYCLES-1.
- HOLD:
  - Events are ignored: no score change and no pulses. Previous zones still update.
  - Timer decrements each cycle; at 0 → PLAY. serve_hold=1 for exactly HOLD_CYCLES cycles.
- OVER:
  - Scores, winner and gameover are frozen. Events are ignored.
- restart (any state, priority over events): next cycle s1=s2=0, winner=0, gameover=0, serve_hold=0, state PLAY, timer 0. Previous zones are not cleared.
- Reset (rst_n low, async): s1=s2=0, point_p1=point_p2=0, serve_hold=0, gameover=0, winner=0, state PLAY, timer 0, all previous zones = IN. Reset mid-HOLD or mid-OVER aborts immediately.
- All outputs are registered. A score change and its pulse appear one cycle after the exit edge.

Decomposition:
- Shared package object_package:
  - typedef zone_t {ZONE_IN, ZONE_LEFT, ZONE_RIGHT};
  - typedef match_state_t {ST_PLAY, ST_HOLD, ST_OVER};
  - winner encoding constants WIN_NONE/WIN_P1/WIN_P2.
- Sub-module ball_exit_detector (one instance per ball): classifies the zone, registers the previous zone, and outputs a registered-edge-derived exit_left/exit_right pair. Instantiated via a generate loop.

Test Plan:
1. Ball0 x moves 320→700 (<<FBITS) and holds there for 10 cycles → s1=1 once, point_p1 one pulse, serve_hold high for HOLD_CYCLES (set to 4 in bench), then PLAY.
2. Both balls exit in the same cycle, ball0 left (x=-5 wrapped) and ball1 right → s1=1, s2=1, both pulses in the same cycle, enters HOLD.
3. Exit during HOLD (ball re-enters, then exits again while serve_hold=1) → no score change; a later exit in PLAY scores normally.
4. WIN_SCORE=7, WIN_BY=1, s1=6 and s2=3, p1 scores → s1=7, gameover=1, winner=1; further exits leave the scores frozen.
5. WIN_BY=2, s1=6 and s2=6, p1 scores → s1=7, no win, HOLD; p1 scores again → s1=8, winner=1.
6. SBITS=3, WIN_SCORE=7, WIN_BY=3, s1=6 and s2=5, p1 scores twice in one cycle → s1 saturates at 7 with no win (lead 2), HOLD. Then assert restart, and separately assert rst_n low mid-HOLD → all outputs 0, state PLAY.
